spi_register_peripheral: RTL and testbench

- SPI target (mode 0, write-only) that receives 16-bit frames from an off-chip controller on three pins.
- Decodes each frame into a 5-entry configuration register file.
- Drives the five control buses consumed by pwm_peripheral: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Sits directly upstream of pwm_peripheral inside the top-level wrapper. SCLK/COPI/nCS come from ui_in[0]/ui_in[1]/ui_in[2].

---
 rtl/spi_register_peripheral_if.sv | 11 +
 rtl/spi_register_peripheral.sv | 135 +++++++++++++
 tb/tb_spi_register_peripheral.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_register_peripheral_if.sv
// SPI target pin bundle: the three controller-driven wires (sclk, copi, ncs).
// master drives all three pins; slave only observes them.
// The wires are asynchronous to the peripheral clock and are synchronized downstream.
interface spi_register_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_register_peripheral.sv
// Write-only SPI mode-0 target that decodes 16-bit frames (R/W, addr[6:0], data[7:0])
// into a 5-entry configuration register file feeding pwm_peripheral.
// Ports: clk/rst_n (async active-low); spi (slave modport: sclk, copi, ncs, all async);
//   five 8-bit register outputs; txn_commit pulses for one clk on each accepted write.
// Register update lands SYNC_STAGES+2 clks after ncs rises; no backpressure (SPI is push-only).
module spi_register_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  spi_register_peripheral_if.slave         spi,
  output logic [7:0]                       en_reg_out_7_0,
  output logic [7:0]                       en_reg_out_15_8,
  output logic [7:0]                       en_reg_pwm_7_0,
  output logic [7:0]                       en_reg_pwm_15_8,
  output logic [7:0]                       pwm_duty_cycle,
  output logic                             txn_commit
);

  localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Synchronizer chains; bit [SYNC_STAGES-1] is the synced value.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  state_t      state, state_n;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_q;
  logic        clr, shift_en, do_commit, frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // A frame is accepted only with exactly 16 bits, the write flag set and an in-range address.
  assign frame_ok = (bit_cnt == 5'd16) && shift_q[15] && (shift_q[14:8] <= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    do_commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (ncs_fall) begin
          clr     = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // Re-select restarts the frame; a deselect ends it. An sclk edge coinciding
        // with ncs rising is dropped because ncs_s is already high.
        if (ncs_fall)                clr      = 1'b1;
        else if (ncs_rise)           state_n  = COMMIT;
        else if (sclk_rise && !ncs_s) shift_en = 1'b1;
      end
      COMMIT: begin
        do_commit = frame_ok;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[14:0], copi_s};
      // Saturate at 17 so any overrun stays distinguishable from a clean 16.
      if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      txn_commit      <= 1'b0;
    end else begin
      txn_commit <= do_commit;
      if (do_commit) begin
        case (shift_q[14:8])
          7'd0:    en_reg_out_7_0  <= shift_q[7:0];
          7'd1:    en_reg_out_15_8 <= shift_q[7:0];
          7'd2:    en_reg_pwm_7_0  <= shift_q[7:0];
          7'd3:    en_reg_pwm_15_8 <= shift_q[7:0];
          7'd4:    pwm_duty_cycle  <= shift_q[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_register_peripheral.sv
// Scoreboard bench: stimulus pushes expected register snapshots on each accepted write,
// a negedge monitor pops one per txn_commit pulse and compares all five outputs.
// Directed cases first, then randomized frames against an arithmetic reference model.
module tb_spi_register_peripheral;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_register_peripheral_if spi_bus ();

  logic [7:0] o0, o1, o2, o3, o4;
  logic       txn_commit;

  spi_register_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi_bus),
    .en_reg_out_7_0  (o0),
    .en_reg_out_15_8 (o1),
    .en_reg_pwm_7_0  (o2),
    .en_reg_pwm_15_8 (o3),
    .pwm_duty_cycle  (o4),
    .txn_commit      (txn_commit)
  );

  wire [39:0] dut_regs = {o4, o3, o2, o1, o0};

  int tests = 0;
  int fails = 0;
  logic [7:0]  model [5];
  logic [39:0] exp_q [$];

  function automatic logic [39:0] model_snapshot();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit pulse must match the oldest pending expected snapshot.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && txn_commit === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got pulse with regs %h, expected no pulse at %0t", dut_regs, $time);
      end else begin
        check("commit_regs", dut_regs, exp_q.pop_front());
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends word[n-1:0] MSB first; sclk half period is 6 clks (above the 4-clk minimum).
  task automatic shift_bits(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bus.copi = word[i];
      wait_clk(6);
      spi_bus.sclk = 1'b1;
      wait_clk(6);
      spi_bus.sclk = 1'b0;
    end
  endtask

  // Reference model: a frame updates state only if it is exactly 16 bits, a write, addr <= 4.
  task automatic issue_frame(input bit rw, input logic [6:0] addr, input logic [7:0] data,
                             input int nbits, input int gap);
    logic [15:0] frame;
    logic [31:0] word;
    frame = {rw, addr, data};
    if (nbits == 17)      word = {15'd0, frame, 1'b1};
    else if (nbits == 15) word = {17'd0, frame[15:1]};
    else                  word = {16'd0, frame};
    if (nbits == 16 && rw && addr <= 7'd4) begin
      model[addr] = data;
      exp_q.push_back(model_snapshot());
    end
    @(posedge clk); #1;
    spi_bus.ncs = 1'b0;
    wait_clk(6);
    shift_bits(word, nbits);
    wait_clk(6);
    spi_bus.ncs = 1'b1;
    wait_clk(gap);
    @(negedge clk); #1;
    check("regs_after_frame", dut_regs, model_snapshot());
    check("pending_commits", 40'(exp_q.size()), 40'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spi_bus.ncs  = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    int guard;
    do_reset();
    wait_clk(4);
    check("reset_regs", dut_regs, 40'd0);
    check("reset_commit", {39'd0, txn_commit}, 40'd0);
    rst_n = 1'b1;
    wait_clk(4);
    check("post_reset_regs", dut_regs, 40'd0);

    // Basic writes to 0x00 and 0x01.
    issue_frame(1'b1, 7'h00, 8'hF0, 16, 8);
    issue_frame(1'b1, 7'h01, 8'h0F, 16, 8);

    // Back-to-back writes to 0x04 with minimum ncs high time.
    issue_frame(1'b1, 7'h04, 8'h80, 16, 4);
    issue_frame(1'b1, 7'h04, 8'hFF, 16, 4);

    // Out-of-range address and a read: no state change.
    issue_frame(1'b1, 7'h05, 8'hAA, 16, 8);
    issue_frame(1'b0, 7'h02, 8'h55, 16, 8);

    // Short and overrun frames discarded, then the correct frame lands.
    issue_frame(1'b1, 7'h02, 8'h55, 15, 8);
    issue_frame(1'b1, 7'h02, 8'h55, 17, 8);
    check("pwm_7_0_still_zero", {32'd0, o2}, 40'd0);
    issue_frame(1'b1, 7'h02, 8'h55, 16, 8);

    // Reset after 9 bits of a write to 0x03.
    @(posedge clk); #1;
    spi_bus.ncs = 1'b0;
    wait_clk(6);
    shift_bits({16'd0, 1'b1, 7'h03, 8'hC3}, 9);
    do_reset();
    wait_clk(3);
    check("midframe_reset_regs", dut_regs, 40'd0);
    check("midframe_reset_commit", {39'd0, txn_commit}, 40'd0);
    rst_n = 1'b1;
    wait_clk(6);
    check("after_release_regs", dut_regs, 40'd0);
    issue_frame(1'b1, 7'h03, 8'hC3, 16, 8);

    // One-clk ncs glitch mid-frame: the partial frame must never commit.
    @(posedge clk); #1;
    spi_bus.ncs = 1'b0;
    wait_clk(6);
    shift_bits({16'd0, 1'b1, 7'h01, 8'hAA}, 5);
    spi_bus.ncs = 1'b1;
    wait_clk(1);
    spi_bus.ncs = 1'b0;
    shift_bits({29'd0, 3'b101}, 3);
    wait_clk(6);
    spi_bus.ncs = 1'b1;
    wait_clk(8);
    @(negedge clk); #1;
    check("glitch_no_change", dut_regs, model_snapshot());
    issue_frame(1'b1, 7'h00, 8'h3C, 16, 8);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      int len_sel;
      int nbits;
      len_sel = $urandom_range(0, 9);
      nbits = (len_sel == 0) ? 15 : (len_sel == 1) ? 17 : 16;
      issue_frame(($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)),
                  8'($urandom), nbits, $urandom_range(4, 10));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      wait_clk(1);
      guard++;
    end
    check("final_queue_empty", 40'(exp_q.size()), 40'd0);
    check("final_regs", dut_regs, model_snapshot());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
